// File: rtl/apu_mix_sched.sv
`default_nettype none
// ============================================================================
// Module   : apu_mix_sched
// Function : Polls N voices in fixed order, sums their signed samples in one
//            shared accumulator, saturates, and presents one mixed sample.
// Option   : APU_MIX_SCHED_VOLUME_EN adds a per-voice arithmetic right shift.
// Revision : 1.0  initial release
// ============================================================================
module apu_mix_sched #(
  parameter int N_VOICES = 4,
  parameter int W        = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_VOICES-1:0]   voice_en,
  output logic [N_VOICES-1:0]   voice_req,
  input  logic [N_VOICES-1:0]   voice_vld,
  input  logic [N_VOICES*W-1:0] voice_sample,
`ifdef APU_MIX_SCHED_VOLUME_EN
  input  logic [N_VOICES*3-1:0] voice_shift,
`endif
  output logic [W-1:0]          out_sample,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [N_VOICES-1:0]   underrun,
  input  logic [N_VOICES-1:0]   underrun_clr
);

  localparam int IDX_W = $clog2(N_VOICES);
  localparam int ACC_W = W + IDX_W;
  localparam logic signed [ACC_W-1:0] c_sat_max = {{(IDX_W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min = {{(IDX_W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [IDX_W-1:0]    c_last_idx = IDX_W'(N_VOICES-1);
  localparam logic [7:0]          c_to_last  = 8'(TIMEOUT-1);
  localparam logic [N_VOICES-1:0] c_one      = N_VOICES'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SAT   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [7:0]              r_cnt, w_cnt_nxt;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [N_VOICES-1:0]     r_req, w_req_nxt;
  logic [W-1:0]            r_out, w_out_nxt;
  logic                    r_vld, w_vld_nxt;
  logic [N_VOICES-1:0]     r_underrun, w_ur_set;

  logic signed [W-1:0]     w_samp;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_addend;
  logic [2:0]              w_shift;
  logic                    w_xfer;
  logic                    w_adv;

  assign w_samp = voice_sample[r_idx*W +: W];
  assign w_ext  = w_samp;
`ifdef APU_MIX_SCHED_VOLUME_EN
  assign w_shift = voice_shift[r_idx*3 +: 3];
`else
  assign w_shift = 3'd0;
`endif
  assign w_addend = w_ext >>> w_shift;
  // r_req is one-hot at r_idx, so any overlap with vld is the current voice
  assign w_xfer   = |(r_req & voice_vld);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_req_nxt   = r_req;
    w_out_nxt   = r_out;
    w_vld_nxt   = r_vld;
    w_ur_set    = '0;
    w_adv       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_acc_nxt = '0;
        w_idx_nxt = '0;
        w_cnt_nxt = '0;
        w_req_nxt = '0;
        if (en) begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = voice_en[0] ? c_one : '0;
        end
      end
      S_FETCH: begin
        if (r_req == '0) begin
          // Unarmed cycle: the gap after a previous voice, or a skipped voice
          if (voice_en[r_idx]) begin
            w_req_nxt = c_one << r_idx;
            w_cnt_nxt = '0;
          end else begin
            w_adv = 1'b1;
          end
        end else if (w_xfer) begin
          w_acc_nxt = r_acc + w_addend;
          w_adv     = 1'b1;
        end else if (r_cnt == c_to_last) begin
          w_ur_set = (c_one << r_idx) & voice_en;
          w_adv    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_SAT: begin
        if (r_acc > c_sat_max)      w_out_nxt = c_sat_max[W-1:0];
        else if (r_acc < c_sat_min) w_out_nxt = c_sat_min[W-1:0];
        else                        w_out_nxt = r_acc[W-1:0];
        w_vld_nxt   = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_rdy) begin
          w_vld_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_adv) begin
      w_req_nxt = '0;
      w_cnt_nxt = '0;
      if (r_idx == c_last_idx) w_state_nxt = S_SAT;
      else                     w_idx_nxt   = r_idx + IDX_W'(1);
    end

    // Dropping en abandons any partial frame; out_sample keeps its value
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_req_nxt   = '0;
      w_vld_nxt   = 1'b0;
      w_acc_nxt   = '0;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_req      <= '0;
      r_out      <= '0;
      r_vld      <= 1'b0;
      r_underrun <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      r_req      <= w_req_nxt;
      r_out      <= w_out_nxt;
      r_vld      <= w_vld_nxt;
      r_underrun <= (r_underrun & ~underrun_clr) | w_ur_set;
    end
  end

  assign voice_req  = r_req;
  assign out_sample = r_out;
  assign out_vld    = r_vld;
  assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_apu_mix_sched.sv
`default_nettype none
// Randomized and directed frames for apu_mix_sched, checked against a
// frame-level reference model (per-voice response delay -> sum, underrun).
module tb_apu_mix_sched;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst, en, out_vld, out_rdy;
  logic [N-1:0]   voice_en, voice_req, voice_vld, underrun, underrun_clr;
  logic [N*W-1:0] voice_sample;
  logic [W-1:0]   out_sample;
`ifdef APU_MIX_SCHED_VOLUME_EN
  logic [N*3-1:0] voice_shift;
`endif

  apu_mix_sched #(.N_VOICES(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en),
    .voice_en(voice_en), .voice_req(voice_req), .voice_vld(voice_vld),
    .voice_sample(voice_sample),
`ifdef APU_MIX_SCHED_VOLUME_EN
    .voice_shift(voice_shift),
`endif
    .out_sample(out_sample), .out_vld(out_vld), .out_rdy(out_rdy),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame description: voice i answers its request in request-cycle dly+1
  logic [N-1:0] f_en;
  logic [W-1:0] f_smp [N];
  int           f_dly [N];
  int           f_sh  [N];
  logic [N-1:0] exp_ur;

  task automatic set_frame(input logic [N-1:0] e,
                           input logic [W-1:0] s0, input logic [W-1:0] s1,
                           input logic [W-1:0] s2, input logic [W-1:0] s3,
                           input int d0, input int d1, input int d2, input int d3);
    f_en = e;
    f_smp[0] = s0; f_smp[1] = s1; f_smp[2] = s2; f_smp[3] = s3;
    f_dly[0] = d0; f_dly[1] = d1; f_dly[2] = d2; f_dly[3] = d3;
    for (int i = 0; i < N; i++) f_sh[i] = 0;
  endtask

  task automatic apply_frame();
    voice_en = f_en;
    for (int i = 0; i < N; i++) voice_sample[i*W +: W] = f_smp[i];
`ifdef APU_MIX_SCHED_VOLUME_EN
    for (int i = 0; i < N; i++) voice_shift[i*3 +: 3] = 3'(f_sh[i]);
`endif
  endtask

  function automatic logic [W-1:0] model_sum();
    int s = 0;
    for (int i = 0; i < N; i++)
      if (f_en[i] && f_dly[i] < TO) s += (int'($signed(f_smp[i])) >>> f_sh[i]);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[W-1:0];
  endfunction

  task automatic run_frame(input int hold, input logic [N-1:0] clr, input bit drop_en);
    int cnt [N];
    int cyc = 0;
    int first = -1;
    bit ok = 1'b1;
    bit st_ok = 1'b1;
    bit lat_chk = (f_en == '1);
    logic [N-1:0] prev = '0;
    logic [W-1:0] exp_s, held;
    exp_s = model_sum();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      if (f_en[i] && f_dly[i] >= TO) exp_ur[i] = 1'b1;
      if (f_dly[i] != 0) lat_chk = 1'b0;
    end
    apply_frame();
    en = 1'b1; out_rdy = 1'b0; voice_vld = '0;
    while (cyc < 400) begin
      @(negedge clk);
      if (out_vld) break;
      if (voice_req != '0 && first < 0) first = cyc;
      if ($countones(voice_req) > 1) ok = 1'b0;
      if (prev != '0 && voice_req != '0 && voice_req != prev) ok = 1'b0;
      if ((voice_req & ~f_en) != '0) ok = 1'b0;
      prev = voice_req;
      for (int i = 0; i < N; i++) begin
        if (voice_req[i]) cnt[i]++;
        voice_vld[i] = voice_req[i] && (cnt[i] > f_dly[i]);
      end
      cyc++;
    end
    voice_vld = '0;
    if (cyc >= 400) begin
      check("frame_timeout", 32'(out_vld), 32'd1);
      return;
    end
    check("req_protocol", 32'(ok), 32'd1);
    if (lat_chk) check("latency", 32'(cyc - first), 32'(2*N));
    for (int i = 0; i < N; i++) begin
      int e = !f_en[i] ? 0 : (f_dly[i] + 1 < TO ? f_dly[i] + 1 : TO);
      check($sformatf("req_cycles_v%0d", i), 32'(cnt[i]), 32'(e));
    end
    check("out_sample", 32'(out_sample), 32'(exp_s));
    check("underrun", 32'(underrun), 32'(exp_ur));
    held = out_sample;
    for (int h = 0; h < hold; h++) begin
      underrun_clr = (h == 0) ? clr : '0;
      @(negedge clk);
      if (!out_vld || out_sample !== held || voice_req != '0) st_ok = 1'b0;
    end
    underrun_clr = '0;
    if (hold > 0) begin
      exp_ur &= ~clr;
      check("hold_stable", 32'(st_ok), 32'd1);
      check("underrun_after_clr", 32'(underrun), 32'(exp_ur));
    end
    if (drop_en) begin
      en = 1'b0;
      @(negedge clk);
      check("drop_en_vld", {30'd0, out_vld, |voice_req}, 32'd0);
      check("drop_en_hold", 32'(out_sample), 32'(held));
    end else begin
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      check("vld_after_xfer", 32'(out_vld), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; voice_en = '0; voice_vld = '0; voice_sample = '0;
    out_rdy = 1'b0; underrun_clr = '0; exp_ur = '0;
`ifdef APU_MIX_SCHED_VOLUME_EN
    voice_shift = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_req", 32'(voice_req), 32'd0);
    check("rst_vld", 32'(out_vld), 32'd0);
    check("rst_sample", 32'(out_sample), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;

    set_frame(4'b1111, 16'h1000, 16'h0200, 16'hFFFF, 16'h0010, 0, 0, 0, 0);
    run_frame(20, '0, 1'b0);
    set_frame(4'b1111, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 0, 1, 2, 0);
    run_frame(1, '0, 1'b0);
    set_frame(4'b1111, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 0, 0, 3, 0);
    run_frame(0, '0, 1'b0);
    // Voice 1 never answers, then answers in the last allowed cycle
    set_frame(4'b1111, 16'h0100, 16'h2000, 16'h0020, 16'h0003, 0, 99, 0, 0);
    run_frame(2, 4'b0010, 1'b0);
    set_frame(4'b1111, 16'h0100, 16'h2000, 16'h0020, 16'h0003, 0, 14, 0, 0);
    run_frame(0, '0, 1'b0);
    set_frame(4'b0101, 16'h0123, 16'h7FFF, 16'hF000, 16'h7FFF, 2, 0, 0, 0);
    run_frame(3, '0, 1'b1);
    // Leave an underrun set, then reset mid-frame at voice 2
    set_frame(4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 0, 20, 0);
    run_frame(0, '0, 1'b0);
    set_frame(4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 0, 0, 0);
    apply_frame();
    en = 1'b1;
    begin
      int c = 0;
      while (c < 50 && !voice_req[2]) begin
        @(negedge clk);
        voice_vld = voice_req;
        c++;
      end
      check("reach_voice2", 32'(voice_req[2]), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", 32'(voice_req), 32'd0);
    check("midrst_vld", 32'(out_vld), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0; en = 1'b0; voice_vld = '0; exp_ur = '0;
    @(negedge clk);

`ifdef APU_MIX_SCHED_VOLUME_EN
    set_frame(4'b1111, 16'h4000, 16'h8000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    f_sh[0] = 2; f_sh[1] = 1;
    run_frame(0, '0, 1'b0);
`endif

    for (int f = 0; f < 30; f++) begin
      f_en = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        f_smp[i] = 16'($urandom);
        f_dly[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 20));
`ifdef APU_MIX_SCHED_VOLUME_EN
        f_sh[i] = int'($urandom_range(0, 7));
`else
        f_sh[i] = 0;
`endif
      end
      run_frame(int'($urandom_range(0, 3)), 4'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
